// File: rtl/mul_issue_ctrl_pkg.sv
// Shared multiplier-path types: reservation-station packet, function encodings,
// per-instruction metadata carried beside the multiplier, and buffered CDB results.
package mul_issue_ctrl_pkg;

   localparam int XLEN    = 32;
   localparam int PRF_LEN = 6;
   localparam int ROB_LEN = 5;

   typedef enum logic [1:0] {
      ALU_MUL    = 2'd0,
      ALU_MULH   = 2'd1,
      ALU_MULHSU = 2'd2,
      ALU_MULHU  = 2'd3
   } ALU_MUL_FUNC;

   typedef struct packed {
      ALU_MUL_FUNC         mul_func;
      logic [XLEN-1:0]     opa_value;
      logic [XLEN-1:0]     opb_value;
      logic [PRF_LEN-1:0]  dest_preg_idx;
      logic [ROB_LEN-1:0]  rob_idx;
      logic [XLEN-1:0]     PC;
   } RS_MUL_PACKET;

   // kill must stay the MSB: the FIFO's broadcast kill sets the top bit of every entry
   typedef struct packed {
      logic                kill;
      ALU_MUL_FUNC         func;
      logic                neg;
      logic [PRF_LEN-1:0]  dest;
      logic [ROB_LEN-1:0]  rob;
      logic [XLEN-1:0]     PC;
   } MUL_META;

   typedef struct packed {
      logic [XLEN-1:0]     value;
      logic [PRF_LEN-1:0]  dest;
      logic [ROB_LEN-1:0]  rob;
      logic [XLEN-1:0]     PC;
   } MUL_RESULT;

   function automatic logic opa_signed(input ALU_MUL_FUNC f);
      return f != ALU_MULHU;
   endfunction

   function automatic logic opb_signed(input ALU_MUL_FUNC f);
      return (f == ALU_MUL) || (f == ALU_MULH);
   endfunction

endpackage

// File: rtl/mul_meta_fifo.sv
// Synchronous ring FIFO with occupancy count, clear, and a broadcast kill that sets the MSB of every entry.
// Head is registered (zero latency after push edge); push while full is accepted only together with a pop.
module mul_meta_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         push_i,
   input  logic [W-1:0]                 push_dat_i,
   input  logic                         pop_i,
   input  logic                         clear_i,
   input  logic                         kill_all_i,
   output logic [W-1:0]                 head_dat_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign head_dat_o = mem_q[rd_q];
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_pop)  rd_d = ptr_inc(rd_q);
         if (do_push) wr_d = ptr_inc(wr_q);
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_all_i) mem_q[i][W-1] <= 1'b1;
         end
         if (do_push && !clear_i) mem_q[wr_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiplier issue/result controller: magnitudes out, sign fix-up on return, in-order result queue to the CDB.
// Issue-to-cdb_valid is STAGE+1 cycles; issue_ready is a credit check over in-flight plus queued results.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int STAGE      = 8,
   parameter int OUTQ_DEPTH = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  RS_MUL_PACKET        rs_mul_packet,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic                squash,
   output logic                mult_start,
   output logic [2*XLEN-1:0]   mult_mcand,
   output logic [2*XLEN-1:0]   mult_mplier,
   input  logic [2*XLEN-1:0]   mult_product,
   input  logic                mult_done,
   output logic                cdb_valid,
   output logic [XLEN-1:0]     cdb_value,
   output logic [PRF_LEN-1:0]  cdb_prf_idx,
   output logic [ROB_LEN-1:0]  cdb_rob_idx,
   output logic [XLEN-1:0]     cdb_PC,
   input  logic                cdb_grant
);

   localparam int MCW = $clog2(STAGE+1);
   localparam int QCW = $clog2(OUTQ_DEPTH+1);
   localparam int UW  = $clog2(STAGE+OUTQ_DEPTH+1);

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   MUL_META           meta_in, meta_head;
   MUL_RESULT         res_in, res_head;
   logic              meta_empty, outq_empty;
   logic [MCW-1:0]    meta_cnt;
   logic [QCW-1:0]    outq_cnt;
   logic [UW-1:0]     used;
   logic              done_live;
   logic [2*XLEN-1:0] full_prod;

   assign a_neg = opa_signed(rs_mul_packet.mul_func) && rs_mul_packet.opa_value[XLEN-1];
   assign b_neg = opb_signed(rs_mul_packet.mul_func) && rs_mul_packet.opb_value[XLEN-1];
   assign a_mag = a_neg ? -rs_mul_packet.opa_value : rs_mul_packet.opa_value;
   assign b_mag = b_neg ? -rs_mul_packet.opb_value : rs_mul_packet.opb_value;

   // Credits cover both in-flight and queued results, so a stalled CDB can never overflow the queue
   assign used        = UW'(meta_cnt) + UW'(outq_cnt);
   assign issue_ready = reset && !squash && (used < UW'(OUTQ_DEPTH));
   assign mult_start  = issue_valid && issue_ready;
   assign mult_mcand  = mult_start ? {{XLEN{1'b0}}, a_mag} : '0;
   assign mult_mplier = mult_start ? {{XLEN{1'b0}}, b_mag} : '0;

   assign meta_in = '{kill: 1'b0,
                      func: rs_mul_packet.mul_func,
                      neg:  a_neg ^ b_neg,
                      dest: rs_mul_packet.dest_preg_idx,
                      rob:  rs_mul_packet.rob_idx,
                      PC:   rs_mul_packet.PC};

   // A done with nothing tracked is a leftover from before reset
   assign done_live = mult_done && !meta_empty;

   // Negate the full double-width product; negating halves separately would lose the borry across them
   assign full_prod = meta_head.neg ? (~mult_product + (2*XLEN)'(1)) : mult_product;

   assign res_in.value = (meta_head.func == ALU_MUL) ? full_prod[XLEN-1:0]
                                                     : full_prod[2*XLEN-1:XLEN];
   assign res_in.dest  = meta_head.dest;
   assign res_in.rob   = meta_head.rob;
   assign res_in.PC    = meta_head.PC;

   mul_meta_fifo #(.W($bits(MUL_META)), .DEPTH(STAGE)) u_meta (
      .clk_i      (clock),
      .rst_n_i    (reset),
      .push_i     (mult_start),
      .push_dat_i (meta_in),
      .pop_i      (done_live),
      .clear_i    (1'b0),
      .kill_all_i (squash),
      .head_dat_o (meta_head),
      .empty_o    (meta_empty),
      .count_o    (meta_cnt)
   );

   mul_meta_fifo #(.W($bits(MUL_RESULT)), .DEPTH(OUTQ_DEPTH)) u_outq (
      .clk_i      (clock),
      .rst_n_i    (reset),
      .push_i     (done_live && !meta_head.kill),
      .push_dat_i (res_in),
      .pop_i      (cdb_valid && cdb_grant),
      .clear_i    (squash),
      .kill_all_i (1'b0),
      .head_dat_o (res_head),
      .empty_o    (outq_empty),
      .count_o    (outq_cnt)
   );

   assign cdb_valid   = !outq_empty;
   assign cdb_value   = res_head.value;
   assign cdb_prf_idx = res_head.dest;
   assign cdb_rob_idx = res_head.rob;
   assign cdb_PC      = res_head.PC;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with an 8-stage behavioural multiplier beside it and a queue-based reference model.
module tb_mul_issue_ctrl;
   import mul_issue_ctrl_pkg::*;

   localparam int STAGE = 8;
   localparam int OUTQ  = 10;

   logic               clock = 1'b0;
   logic               reset, issue_valid, squash, cdb_grant;
   RS_MUL_PACKET       rs_mul_packet;
   logic               issue_ready, mult_start, mult_done, cdb_valid;
   logic [2*XLEN-1:0]  mult_mcand, mult_mplier, mult_product;
   logic [XLEN-1:0]    cdb_value, cdb_PC;
   logic [PRF_LEN-1:0] cdb_prf_idx;
   logic [ROB_LEN-1:0] cdb_rob_idx;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   mul_issue_ctrl #(.STAGE(STAGE), .OUTQ_DEPTH(OUTQ)) dut (
      .clock         (clock),
      .reset         (reset),
      .rs_mul_packet (rs_mul_packet),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .squash        (squash),
      .mult_start    (mult_start),
      .mult_mcand    (mult_mcand),
      .mult_mplier   (mult_mplier),
      .mult_product  (mult_product),
      .mult_done     (mult_done),
      .cdb_valid     (cdb_valid),
      .cdb_value     (cdb_value),
      .cdb_prf_idx   (cdb_prf_idx),
      .cdb_rob_idx   (cdb_rob_idx),
      .cdb_PC        (cdb_PC),
      .cdb_grant     (cdb_grant)
   );

   // Unsigned pipelined multiplier, never reset
   bit                pv [STAGE];
   logic [2*XLEN-1:0] pp [STAGE];
   always @(posedge clock) begin
      pv[0] <= mult_start;
      pp[0] <= mult_mcand * mult_mplier;
      for (int i = 1; i < STAGE; i++) begin
         pv[i] <= pv[i-1];
         pp[i] <= pp[i-1];
      end
   end
   assign mult_done    = pv[STAGE-1];
   assign mult_product = pp[STAGE-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input ALU_MUL_FUNC f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (f != ALU_MULHU && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
      eb = ((f == ALU_MUL || f == ALU_MULH) && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
      p  = ea * eb;
      return (f == ALU_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [63:0] ref_mag(input bit sgn, input logic [31:0] x);
      return (sgn && x[31]) ? {32'h0, 32'(32'h0 - x)} : {32'h0, x};
   endfunction

   typedef struct {
      logic [31:0]        val;
      logic [PRF_LEN-1:0] prf;
      logic [ROB_LEN-1:0] rob;
      logic [31:0]        pc;
   } res_t;
   typedef struct {
      int   due;
      bit   killed;
      res_t r;
   } pend_t;

   res_t  outq [$];
   pend_t pend [$];
   bit    live = 0;
   int    cyc  = 0;

   always @(posedge clock) begin : model
      pend_t p;
      bit    acc;
      if (!reset) begin
         pend.delete();
         outq.delete();
         live = 1;
      end else if (live) begin
         acc = issue_valid && !squash && (pend.size() + outq.size() < OUTQ);
         if (cdb_grant && outq.size() > 0) void'(outq.pop_front());
         if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (!p.killed) outq.push_back(p.r);
         end
         if (squash) begin
            outq.delete();
            foreach (pend[i]) pend[i].killed = 1;
         end
         if (acc) begin
            p.due    = cyc + STAGE;
            p.killed = 0;
            p.r.val  = ref_mul(rs_mul_packet.mul_func, rs_mul_packet.opa_value, rs_mul_packet.opb_value);
            p.r.prf  = rs_mul_packet.dest_preg_idx;
            p.r.rob  = rs_mul_packet.rob_idx;
            p.r.pc   = rs_mul_packet.PC;
            pend.push_back(p);
         end
      end
      cyc++;
   end

   always @(negedge clock) begin : compare
      bit   er;
      res_t h;
      ALU_MUL_FUNC f;
      if (live) begin
         f  = rs_mul_packet.mul_func;
         er = reset && !squash && (pend.size() + outq.size() < OUTQ);
         chk("issue_ready", 64'(issue_ready), 64'(er));
         chk("mult_start", 64'(mult_start), 64'(issue_valid && er));
         if (issue_valid && er) begin
            chk("mult_mcand", mult_mcand, ref_mag(f != ALU_MULHU, rs_mul_packet.opa_value));
            chk("mult_mplier", mult_mplier,
                ref_mag(f == ALU_MUL || f == ALU_MULH, rs_mul_packet.opb_value));
         end
         chk("cdb_valid", 64'(cdb_valid), 64'(outq.size() > 0));
         if (outq.size() > 0) begin
            h = outq[0];
            chk("cdb_value", 64'(cdb_value), 64'(h.val));
            chk("cdb_prf_idx", 64'(cdb_prf_idx), 64'(h.prf));
            chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(h.rob));
            chk("cdb_PC", 64'(cdb_PC), 64'(h.pc));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pkt(input int k, input ALU_MUL_FUNC f, input logic [31:0] a, input logic [31:0] b);
      rs_mul_packet.mul_func      = f;
      rs_mul_packet.opa_value     = a;
      rs_mul_packet.opb_value     = b;
      rs_mul_packet.dest_preg_idx = PRF_LEN'(k);
      rs_mul_packet.rob_idx       = ROB_LEN'(k);
      rs_mul_packet.PC            = 32'h1000 + 32'(4 * k);
   endtask

   task automatic gen_pkt(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      set_pkt(k, ALU_MUL_FUNC'(kk[1:0]), kk * 32'h9E3779B9, (kk * 32'h01000193) ^ 32'hA5A5A5A5);
   endtask

   task automatic lit(input string nm, input ALU_MUL_FUNC f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expv, input int k);
      set_pkt(k, f, a, b);
      issue_valid = 1;
      cdb_grant   = 1;
      step();
      issue_valid = 0;
      repeat (7) step();
      @(negedge clock);
      chk({nm, "_not_early"}, 64'(cdb_valid), 64'(0));
      step();
      @(negedge clock);
      chk({nm, "_valid"}, 64'(cdb_valid), 64'(1));
      chk({nm, "_value"}, 64'(cdb_value), 64'(expv));
      chk({nm, "_prf"}, 64'(cdb_prf_idx), 64'(PRF_LEN'(k)));
      chk({nm, "_rob"}, 64'(cdb_rob_idx), 64'(ROB_LEN'(k)));
      chk({nm, "_pc"}, 64'(cdb_PC), 64'(32'h1000 + 32'(4 * k)));
      chk({nm, "_model"}, 64'(ref_mul(f, a, b)), 64'(expv));
      step();
   endtask

   initial begin : drive
      int n, first, last, drops, acc;
      reset       = 0;
      issue_valid = 0;
      squash      = 0;
      cdb_grant   = 0;
      set_pkt(0, ALU_MUL, 32'h0, 32'h0);
      step();
      @(negedge clock);
      chk("rst_issue_ready", 64'(issue_ready), 64'(0));
      chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("rst_cdb_value", 64'(cdb_value), 64'(0));
      step();
      reset = 1;
      @(negedge clock);
      chk("post_rst_ready", 64'(issue_ready), 64'(1));
      step();

      lit("mul_neg3",     ALU_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
      lit("mulh_min",     ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2);
      lit("mulhsu_ones",  ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
      lit("mulhu_ones",   ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
      lit("mulh_neg1",    ALU_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 5);

      // Back-to-back issue with the CDB always granting
      cdb_grant = 1;
      n = 0; first = -1; last = -1; drops = 0;
      for (int i = 0; i < 32; i++) begin
         issue_valid = (i < 20);
         gen_pkt(100 + i);
         @(negedge clock);
         if (i < 20 && !issue_ready) drops++;
         if (cdb_valid) begin
            n++;
            if (first < 0) first = i;
            last = i;
         end
         step();
      end
      chk("tput_ready_drops", 64'(drops), 64'(0));
      chk("tput_results", 64'(n), 64'(20));
      chk("tput_first", 64'(first), 64'(9));
      chk("tput_span", 64'(last - first), 64'(19));

      // CDB stalled: credits run out at OUTQ
      cdb_grant = 0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         issue_valid = 1;
         gen_pkt(200 + i);
         @(negedge clock);
         if (mult_start) acc++;
         if (i == 19) chk("bp_ready_low", 64'(issue_ready), 64'(0));
         step();
      end
      chk("bp_accepted", 64'(acc), 64'(10));
      cdb_grant = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         issue_valid = (i < 2);
         gen_pkt(300 + i);
         @(negedge clock);
         if (i == 0) chk("bp_ready_first_grant", 64'(issue_ready), 64'(0));
         if (i == 1) chk("bp_ready_resume", 64'(issue_ready), 64'(1));
         if (cdb_valid) n++;
         step();
      end
      issue_valid = 0;
      chk("bp_results", 64'(n), 64'(11));

      // Squash with 2 queued and 3 in flight, granting in the squash cycle
      cdb_grant = 0;
      for (int i = 0; i < 5; i++) begin
         issue_valid = 1;
         gen_pkt(400 + i);
         step();
      end
      issue_valid = 0;
      repeat (5) step();
      squash      = 1;
      cdb_grant   = 1;
      issue_valid = 1;
      gen_pkt(410);
      @(negedge clock);
      chk("sq_broadcast", 64'(cdb_valid), 64'(1));
      chk("sq_no_start", 64'(mult_start), 64'(0));
      step();
      squash      = 0;
      cdb_grant   = 0;
      issue_valid = 0;
      @(negedge clock);
      chk("sq_cleared", 64'(cdb_valid), 64'(0));
      chk("sq_ready", 64'(issue_ready), 64'(1));
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         @(negedge clock);
         if (cdb_valid) n++;
      end
      chk("sq_no_late_results", 64'(n), 64'(0));

      // One-cycle reset while the multiplier still holds three operations
      cdb_grant = 1;
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1;
         gen_pkt(500 + i);
         step();
      end
      issue_valid = 0;
      repeat (2) step();
      reset       = 0;
      issue_valid = 1;
      gen_pkt(510);
      @(negedge clock);
      chk("rst2_ready_low", 64'(issue_ready), 64'(0));
      chk("rst2_no_start", 64'(mult_start), 64'(0));
      step();
      reset       = 1;
      issue_valid = 0;
      @(negedge clock);
      chk("rst2_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("rst2_cdb_value", 64'(cdb_value), 64'(0));
      chk("rst2_cdb_prf", 64'(cdb_prf_idx), 64'(0));
      chk("rst2_cdb_rob", 64'(cdb_rob_idx), 64'(0));
      chk("rst2_cdb_pc", 64'(cdb_PC), 64'(0));
      chk("rst2_mcand", mult_mcand, 64'(0));
      chk("rst2_ready_high", 64'(issue_ready), 64'(1));
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         @(negedge clock);
         if (cdb_valid) n++;
      end
      chk("rst2_stray_done", 64'(n), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
